// File: rtl/stack_arbiter_if.sv
// ---------------------------------------------------------------------------
// stack_arbiter_if
//   Bundles the two client request/response channels and the hardware stack
//   strobe/data lines seen by stack_arbiter.
//
//   Client n (n = 0,1):
//     reqn    requester -> arbiter  request, sampled in IDLE
//     opn     requester -> arbiter  00 push, 01 pop, 10 top, 11 illegal
//     wdatan  requester -> arbiter  push data
//     gntn    arbiter -> requester  one-cycle grant pulse
//     donen   arbiter -> requester  one-cycle completion pulse
//     errn    arbiter -> requester  valid with donen, 1 = rejected
//     rdatan  arbiter -> requester  last pop/top result
//   Stack side:
//     stk_push/stk_pop/stk_top  arbiter -> stack  one-cycle strobes
//     stk_d_in                  arbiter -> stack  write data
//     stk_d_out                 stack -> arbiter  read data, cycle after strobe
//   Status:
//     depth/full/empty          arbiter -> observers
//
//   Modports: slave = the arbiter, master = clients plus the stack model.
// ---------------------------------------------------------------------------
interface stack_arbiter_if;
  logic       req0;
  logic [1:0] op0;
  logic [7:0] wdata0;
  logic       gnt0;
  logic       done0;
  logic       err0;
  logic [7:0] rdata0;

  logic       req1;
  logic [1:0] op1;
  logic [7:0] wdata1;
  logic       gnt1;
  logic       done1;
  logic       err1;
  logic [7:0] rdata1;

  logic       stk_push;
  logic       stk_pop;
  logic       stk_top;
  logic [7:0] stk_d_in;
  logic [7:0] stk_d_out;

  logic [7:0] depth;
  logic       full;
  logic       empty;

  modport slave (
    input  req0, op0, wdata0, req1, op1, wdata1, stk_d_out,
    output gnt0, done0, err0, rdata0,
    output gnt1, done1, err1, rdata1,
    output stk_push, stk_pop, stk_top, stk_d_in,
    output depth, full, empty
  );

  modport master (
    output req0, op0, wdata0, req1, op1, wdata1, stk_d_out,
    input  gnt0, done0, err0, rdata0,
    input  gnt1, done1, err1, rdata1,
    input  stk_push, stk_pop, stk_top, stk_d_in,
    input  depth, full, empty
  );
endinterface

// File: rtl/stack_arbiter.sv
// ---------------------------------------------------------------------------
// stack_arbiter
//   Two-client round-robin arbiter and sequencer for the shared 256x8
//   hardware stack. One operation is in flight at a time and walks
//   IDLE -> ISSUE -> CAPT -> DONE, one cycle each. Occupancy is tracked here
//   so that overflowing pushes and underflowing pops/tops are rejected
//   without ever strobing the stack.
//
//   Ports:
//     clk  clock
//     rst  asynchronous, active-high reset (shared with the stack)
//     bus  stack_arbiter_if.slave: client channels, stack strobes, status
//
//   Parameter:
//     CAPACITY  maximum stored entries (<= 255; stack slot 0 is never used
//               because the pointer pre-increments on push)
// ---------------------------------------------------------------------------
module stack_arbiter #(
  parameter int CAPACITY = 255
) (
  input  logic           clk,
  input  logic           rst,
  stack_arbiter_if.slave bus
);

  localparam int         DATA_W = 8;
  localparam logic [7:0] CAP    = CAPACITY[7:0];

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_TOP  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // An operation is legal when it cannot overflow or underflow the stack.
  function automatic logic op_legal(input logic [1:0] op, input logic [7:0] dep);
    case (op)
      OP_PUSH: op_legal = (dep != CAP);
      OP_POP,
      OP_TOP:  op_legal = (dep != 8'd0);
      default: op_legal = 1'b0;
    endcase
  endfunction

  state_t state_q, state_d;

  // Favoured client for the next contention (0 or 1).
  logic rr_q;

  // Operation latched at the grant edge.
  logic       win_p0;
  logic [1:0] op_p0;
  logic       legal_p0;

  logic [7:0] depth_q;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic [1:0] err_q, err_d;
  logic [1:0][DATA_W-1:0] rdata_q;

  logic              push_q, push_d;
  logic              pop_q, pop_d;
  logic              top_q, top_d;
  logic [DATA_W-1:0] d_in_q, d_in_d;

  logic              win_d;
  logic [1:0]        op_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic              legal_d;
  logic              grant;
  logic              contend;

  assign contend = bus.req0 && bus.req1;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = 2'b00;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    top_d   = 1'b0;
    d_in_d  = '0;
    grant   = 1'b0;

    if (contend)       win_d = rr_q;
    else if (bus.req1) win_d = 1'b1;
    else               win_d = 1'b0;

    op_sel    = win_d ? bus.op1    : bus.op0;
    wdata_sel = win_d ? bus.wdata1 : bus.wdata0;
    legal_d   = op_legal(op_sel, depth_q);

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant        = 1'b1;
          state_d      = ISSUE;
          gnt_d[win_d] = 1'b1;
          if (legal_d) begin
            case (op_sel)
              OP_PUSH: begin
                push_d = 1'b1;
                d_in_d = wdata_sel;
              end
              OP_POP:  pop_d = 1'b1;
              OP_TOP:  top_d = 1'b1;
              default: ;
            endcase
          end
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        state_d        = DONE;
        done_d[win_p0] = 1'b1;
        err_d[win_p0]  = ~legal_p0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      win_p0   <= 1'b0;
      op_p0    <= 2'b00;
      legal_p0 <= 1'b0;
      depth_q  <= 8'd0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      err_q    <= 2'b00;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      top_q    <= 1'b0;
      d_in_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      top_q   <= top_d;
      d_in_q  <= d_in_d;

      // IDLE -> ISSUE: latch the winning request; rotate only on contention
      if (grant) begin
        win_p0   <= win_d;
        op_p0    <= op_sel;
        legal_p0 <= legal_d;
        if (contend) rr_q <= ~win_d;
      end

      // ISSUE -> CAPT: occupancy follows the strobe that was just issued
      if (state_q == ISSUE && legal_p0) begin
        if (op_p0 == OP_PUSH)     depth_q <= depth_q + 8'd1;
        else if (op_p0 == OP_POP) depth_q <= depth_q - 8'd1;
      end

      // CAPT -> DONE: stack read data is valid one cycle after pop/top
      if (state_q == CAPT && legal_p0 && (op_p0 == OP_POP || op_p0 == OP_TOP))
        rdata_q[win_p0] <= bus.stk_d_out;
    end
  end

  assign bus.gnt0   = gnt_q[0];
  assign bus.gnt1   = gnt_q[1];
  assign bus.done0  = done_q[0];
  assign bus.done1  = done_q[1];
  assign bus.err0   = err_q[0];
  assign bus.err1   = err_q[1];
  assign bus.rdata0 = rdata_q[0];
  assign bus.rdata1 = rdata_q[1];

  assign bus.stk_push = push_q;
  assign bus.stk_pop  = pop_q;
  assign bus.stk_top  = top_q;
  assign bus.stk_d_in = d_in_q;

  assign bus.depth = depth_q;
  assign bus.full  = (depth_q == CAP);
  assign bus.empty = (depth_q == 8'd0);

endmodule

// File: tb/tb_stack_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stack_arbiter
//   Directed bench for stack_arbiter with a behavioural 256x8 stack
//   (pre-incrementing pointer, read data registered one cycle after a
//   pop/top strobe). Inputs are driven and outputs sampled on the falling
//   clock edge.
// ---------------------------------------------------------------------------
module tb_stack_arbiter;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  stack_arbiter_if bus ();

  stack_arbiter #(.CAPACITY(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack
  logic [7:0] mem [256];
  logic [7:0] sp;

  always_ff @(posedge clk) begin
    if (bus.stk_push) mem[sp + 8'd1] <= bus.stk_d_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp            <= 8'd0;
      bus.stk_d_out <= 8'd0;
    end else if (bus.stk_push) begin
      sp <= sp + 8'd1;
    end else if (bus.stk_pop) begin
      bus.stk_d_out <= mem[sp];
      sp            <= sp - 8'd1;
    end else if (bus.stk_top) begin
      bus.stk_d_out <= mem[sp];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full transaction from an IDLE falling edge back to the next IDLE falling edge.
  task automatic run_op(input int c, input logic [1:0] op, input logic [7:0] wd,
                        input logic exp_err, input logic [7:0] exp_rd,
                        input logic [7:0] exp_depth, input string tag);
    logic       legal;
    logic [2:0] exp_stb;
    legal = !exp_err;
    if (!legal)           exp_stb = 3'b000;
    else if (op == 2'b00) exp_stb = 3'b100;
    else if (op == 2'b01) exp_stb = 3'b010;
    else                  exp_stb = 3'b001;

    if (c == 0) begin bus.req0 = 1'b1; bus.op0 = op; bus.wdata0 = wd; end
    else        begin bus.req1 = 1'b1; bus.op1 = op; bus.wdata1 = wd; end

    @(negedge clk);  // ISSUE
    check({tag, "_gnt"}, 32'({bus.gnt1, bus.gnt0}), 32'((c == 0) ? 2'b01 : 2'b10));
    check({tag, "_stb"}, 32'({bus.stk_push, bus.stk_pop, bus.stk_top}), 32'(exp_stb));
    check({tag, "_din"}, 32'(bus.stk_d_in), 32'((exp_stb == 3'b100) ? wd : 8'h00));
    if (c == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;

    @(negedge clk);  // CAPT
    check({tag, "_stb_off"}, 32'({bus.stk_push, bus.stk_pop, bus.stk_top, bus.gnt1, bus.gnt0}), 32'd0);
    check({tag, "_depth"}, 32'(bus.depth), 32'(exp_depth));

    @(negedge clk);  // DONE
    check({tag, "_done"}, 32'({bus.done1, bus.done0}), 32'((c == 0) ? 2'b01 : 2'b10));
    check({tag, "_err"}, 32'({bus.err1, bus.err0}),
          32'(exp_err ? ((c == 0) ? 2'b01 : 2'b10) : 2'b00));
    check({tag, "_rdata"}, 32'((c == 0) ? bus.rdata0 : bus.rdata1), 32'(exp_rd));

    @(negedge clk);  // IDLE
    check({tag, "_done_off"}, 32'({bus.done1, bus.done0}), 32'd0);
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    bus.req0   = 1'b0;
    bus.op0    = 2'b00;
    bus.wdata0 = 8'h00;
    bus.req1   = 1'b0;
    bus.op1    = 2'b00;
    bus.wdata1 = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_outs", 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err0, bus.err1,
                           bus.stk_push, bus.stk_pop, bus.stk_top}), 32'd0);
    check("rst_data", 32'({bus.rdata0, bus.rdata1, bus.stk_d_in, bus.depth}), 32'd0);
    check("rst_flags", 32'({bus.full, bus.empty}), 32'b01);
    rst = 1'b0;
    @(negedge clk);
    check("idle_quiet", 32'({bus.gnt1, bus.gnt0, bus.stk_push}), 32'd0);

    // Basic push / top / pop, then underflow
    run_op(0, 2'b00, 8'hA5, 1'b0, 8'h00, 8'd1, "push_a5");
    check("push_a5_empty", 32'({bus.full, bus.empty}), 32'b00);
    run_op(1, 2'b10, 8'h00, 1'b0, 8'hA5, 8'd1, "top1");
    run_op(1, 2'b01, 8'h00, 1'b0, 8'hA5, 8'd0, "pop1");
    check("pop1_empty", 32'(bus.empty), 32'd1);
    run_op(0, 2'b01, 8'h00, 1'b1, 8'h00, 8'd0, "pop_empty");

    // Contention: both push, client 0 wins, client 1 served four cycles later
    bus.req0 = 1'b1; bus.op0 = 2'b00; bus.wdata0 = 8'h11;
    bus.req1 = 1'b1; bus.op1 = 2'b00; bus.wdata1 = 8'h22;
    @(negedge clk);
    check("rr1_gnt", 32'({bus.gnt1, bus.gnt0}), 32'b01);
    check("rr1_din", 32'(bus.stk_d_in), 32'h11);
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    check("rr1_done", 32'({bus.done1, bus.done0}), 32'b01);
    @(negedge clk);
    check("rr1_idle", 32'({bus.gnt1, bus.gnt0}), 32'b00);
    @(negedge clk);
    check("rr2_gnt", 32'({bus.gnt1, bus.gnt0}), 32'b10);
    check("rr2_din", 32'(bus.stk_d_in), 32'h22);
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rr2_done", 32'({bus.done1, bus.done0, bus.err1}), 32'b100);
    check("rr2_depth", 32'(bus.depth), 32'd2);
    @(negedge clk);

    // Next contention goes to client 1
    bus.req0 = 1'b1; bus.op0 = 2'b01;
    bus.req1 = 1'b1; bus.op1 = 2'b01;
    @(negedge clk);
    check("rr3_gnt", 32'({bus.gnt1, bus.gnt0}), 32'b10);
    check("rr3_stb", 32'({bus.stk_push, bus.stk_pop, bus.stk_top}), 32'b010);
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rr3_rdata", 32'(bus.rdata1), 32'h22);
    check("rr3_depth", 32'(bus.depth), 32'd1);
    repeat (2) @(negedge clk);
    check("rr4_gnt", 32'({bus.gnt1, bus.gnt0}), 32'b01);
    bus.req0 = 1'b0;
    repeat (2) @(negedge clk);
    check("rr4_rdata", 32'(bus.rdata0), 32'h11);
    check("rr4_depth", 32'({bus.depth, bus.empty}), 32'({8'd0, 1'b1}));
    @(negedge clk);

    // Fill to capacity
    for (int i = 0; i < 255; i++)
      run_op(0, 2'b00, 8'(i), 1'b0, 8'h11, 8'(i + 1), "fill");
    check("full_flags", 32'({bus.depth, bus.full, bus.empty}), 32'({8'd255, 1'b1, 1'b0}));
    run_op(1, 2'b00, 8'hEE, 1'b1, 8'h22, 8'd255, "overflow");
    run_op(1, 2'b11, 8'h00, 1'b1, 8'h22, 8'd255, "op_ill");
    run_op(0, 2'b01, 8'h00, 1'b0, 8'hFE, 8'd254, "pop_full");
    check("pop_full_flag", 32'(bus.full), 32'd0);

    // Reset during the ISSUE cycle of a push
    bus.req0 = 1'b1; bus.op0 = 2'b00; bus.wdata0 = 8'h77;
    @(negedge clk);
    check("mid_push_stb", 32'(bus.stk_push), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_stb", 32'({bus.stk_push, bus.gnt0}), 32'd0);
    check("mid_rst_depth", 32'({bus.depth, bus.empty}), 32'({8'd0, 1'b1}));
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_nodone", 32'({bus.done1, bus.done0}), 32'd0);
    end
    run_op(0, 2'b00, 8'h5A, 1'b0, 8'h00, 8'd1, "post_rst_push");
    run_op(0, 2'b01, 8'h00, 1'b0, 8'h5A, 8'd0, "post_rst_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Two-client arbiter and sequencer for the shared 256x8 hardware stack.
- Accepts push/pop/top requests from two requesters (for example, the multicycle control path and an exception/call unit) and grants them round-robin.
- Drives the stack's push/pop/top strobes for exactly one cycle per operation.
- Tracks occupancy to block overflow and underflow, and returns read data with a done/err pulse.

Parameters:
- CAPACITY, 255, maximum stored entries. Must be ≤255: the 8-bit stack pointer starts at 0 and pre-increments on push, so slot 0 is never used.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset; shared with the stack instance
- req0  in  1  client 0 request; sampled only in IDLE
- op0  in  2  client 0 operation: 00 push, 01 pop, 10 top, 11 illegal
- wdata0  in  8  client 0 push data
- gnt0  out  1  one-cycle pulse when client 0's request is accepted
- done0  out  1  one-cycle completion pulse for client 0
- err0  out  1  valid with done0; 1 = operation rejected
- rdata0  out  8  pop/top result for client 0; held until the next successful pop/top for client 0
- req1, op1, wdata1, gnt1, done1, err1, rdata1: same as client 0, for client 1
- stk_push  out  1  stack push strobe
- stk_pop  out  1  stack pop strobe
- stk_top  out  1  stack top strobe
- stk_d_in  out  8  stack write data
- stk_d_out  in  8  stack read data; valid the cycle after a pop/top strobe
- depth  out  8  current entry count
- full  out  1  depth == CAPACITY
- empty  out  1  depth == 0

Behaviour:
- Reset values: all outputs 0, except empty = 1. State IDLE, depth 0, round-robin pointer favours client 0.
- Reset is asynchronous: strobes drop in the same cycle rst rises.
- FSM states: IDLE -> ISSUE -> CAPT -> DONE -> IDLE. Each state lasts exactly one cycle.
- IDLE, no request: remain in IDLE.
- IDLE, one request: that client wins.
- IDLE, both requesting: winner is the client favoured by the round-robin pointer. The pointer then favours the other client.
- At the IDLE->ISSUE edge:
  - latch winner id, op and wdata;
  - gnt<winner> = 1 for the ISSUE cycle;
  - evaluate legality against depth.
- Illegal cases: push with full, pop/top with empty, op 11.
- ISSUE cycle, legal operation: exactly one of stk_push/stk_pop/stk_top is high, a registered output. stk_d_in = latched wdata for push, 0 otherwise.
- ISSUE cycle, illegal operation: no strobe asserted.
- After the grant edge, clients may change req/op/wdata. A client must not re-request until its done pulse.
- At the ISSUE->CAPT edge:
  - legal push: depth +1;
  - legal pop: depth -1;
  - top: depth unchanged;
  - strobes return to 0.
- At the CAPT->DONE edge: for a legal pop or top, rdata<winner> <= stk_d_out.
- DONE cycle: done<winner> = 1; err<winner> = 1 if the operation was illegal, otherwise 0.
- Illegal operations leave rdata and depth unchanged.
- Latency: request seen in IDLE at cycle T -> gnt at T+1 -> done at T+3. A new grant is possible at T+5 at the earliest. Maximum throughput: one operation per 4 cycles.
- Requests arriving outside IDLE are not lost, provided the client holds req; they are evaluated at the next IDLE.
- depth saturates by construction, because illegal operations never strobe the stack; it never wraps.
- full and empty are combinational from depth.
- rst mid-operation: FSM returns to IDLE, depth 0, no done issued. The stack pointer is reset by the same rst, so occupancy stays consistent.

Test Plan:
- After reset, client 0 pushes 0xA5 -> gnt0 at T+1; stk_push high one cycle with stk_d_in = 0xA5; done0 at T+3 with err0 = 0; depth = 1, empty = 0.
- Client 1 top, then client 1 pop -> rdata1 = 0xA5 both times; depth 1 after top, 0 after pop; empty = 1; no stk_push asserted.
- Client 0 pops on empty -> no stack strobe; done0 = 1 with err0 = 1; rdata0 unchanged; depth stays 0.
- Both clients push in the same cycle (0x11 from client 0, 0x22 from client 1) -> client 0 granted first, client 1 granted 4 cycles later. Next contention is won by client 1. Two subsequent pops return 0x22 then 0x11.
- 255 legal pushes -> full = 1, depth = 255. 256th push -> err = 1, no stk_push, depth stays 255. One pop clears full.
- Assert rst during the ISSUE cycle of a push -> stk_push falls immediately; no done pulse; depth = 0. Next push after reset completes normally with depth = 1.
